// File: rtl/processor_pkg.sv
// processor_pkg: shared widths and the fetch sequencer state type.
package processor_pkg;

    localparam int PC_W   = 10;  // program counter width
    localparam int INST_W = 9;   // {TypeBit, OP, reg}
    localparam int KEY_W  = 5;   // branch lookup-table key width

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: control, ROM and decoder signals between the fetch unit
// (master) and its surrounding datapath/ROM/decoder (slave).
interface fetch_unit_if #(
    parameter int PC_W = processor_pkg::PC_W
) ();

    logic                              Start;
    logic                              Halt;
    logic                              LookUp;
    logic                              BranchSense;
    logic                              AccNonZero;
    logic [PC_W-1:0]                   InstAddr;
    logic [processor_pkg::INST_W-1:0]  RomData;
    logic [processor_pkg::INST_W-1:0]  Instruction;
    logic                              InstValid;
    logic                              Done;
    logic [15:0]                       InstCount;

    modport master (
        input  Start, Halt, LookUp, BranchSense, AccNonZero, RomData,
        output InstAddr, Instruction, InstValid, Done, InstCount
    );

    modport slave (
        output Start, Halt, LookUp, BranchSense, AccNonZero, RomData,
        input  InstAddr, Instruction, InstValid, Done, InstCount
    );

endinterface

// File: rtl/branch_lut.sv
// branch_lut: 2^KEY_W-entry branch target table with a combinational read.
// Contents come from the packed LUT_INIT parameter (entry k at bits
// [k*PC_W +: PC_W]), which carries the branch_lut.hex image.
module branch_lut #(
  parameter int                          PC_W     = processor_pkg::PC_W,
  parameter int                          KEY_W    = processor_pkg::KEY_W,
  parameter string                       LUT_FILE = "branch_lut.hex",
  parameter logic [(2**KEY_W)*PC_W-1:0]  LUT_INIT = '0
) (
  input  logic [KEY_W-1:0] key_i,
  output logic [PC_W-1:0]  value_o
);

  localparam int DEPTH = 2**KEY_W;

  logic [PC_W-1:0] lut_mem [DEPTH];

  // NOTE: the table is a ROM image; it is loaded, never reset or written by logic.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      lut_mem[i] = LUT_INIT[i*PC_W +: PC_W];
    end
  end

  assign value_o = lut_mem[key_i];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: two-cycle instruction sequencer (FETCH latches ROM data, ISSUE
// presents it and picks the next PC: halt, table branch or PC+1).
// Build option: define BRANCH_REL_EN to treat table entries as signed PC
// offsets; otherwise entries are absolute target PCs.
module fetch_unit
    import processor_pkg::fetch_state_t, processor_pkg::INST_W,
           processor_pkg::IDLE, processor_pkg::FETCH,
           processor_pkg::ISSUE, processor_pkg::HALTED;
#(
    parameter int                          PC_W     = processor_pkg::PC_W,
    parameter int                          KEY_W    = processor_pkg::KEY_W,
    parameter string                       LUT_FILE = "branch_lut.hex",
    parameter logic [(2**KEY_W)*PC_W-1:0]  LUT_INIT = '0
) (
    input  logic         Clk,
    input  logic         Reset,
    fetch_unit_if.master bus
);

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    fetch_state_t        state_q;
    logic [PC_W-1:0]     pc_q;
    logic [INST_W-1:0]   inst_q;
    logic                valid_q;
    logic                done_q;
    logic [15:0]         count_q;

    logic [PC_W-1:0]     lut_value;
    logic [PC_W-1:0]     branch_target;
    logic                take_branch;
    logic [PC_W-1:0]     pc_next_d;

    branch_lut #(
        .PC_W     (PC_W),
        .KEY_W    (KEY_W),
        .LUT_FILE (LUT_FILE),
        .LUT_INIT (LUT_INIT)
    ) u_lut (
        .key_i   (inst_q[KEY_W-1:0]),
        .value_o (lut_value)
    );

    // PC to fetch after a non-halting issue: taken branch target or PC+1 (wraps).
    always_comb begin
        take_branch = bus.LookUp && (bus.AccNonZero == bus.BranchSense);
`ifdef BRANCH_REL_EN
        // Unsigned add modulo 2^PC_W is the same as adding the signed offset.
        branch_target = pc_q + lut_value;
`else
        branch_target = lut_value;
`endif
        pc_next_d = take_branch ? branch_target : pc_q + PC_W'(1);
    end

    // Sequencer FSM with registered outputs; synchronous active-low reset wins over everything.
    always_ff @(posedge Clk) begin
        // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
        if (!Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE, HALTED: begin
                    if (bus.Start) begin
                        state_q <= FETCH;
                        pc_q    <= '0;
                        count_q <= '0;
                        done_q  <= 1'b0;
                    end
                end
                FETCH: begin
                    inst_q  <= bus.RomData;
                    valid_q <= 1'b1;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    if (count_q != COUNT_MAX) begin
                        count_q <= count_q + 16'd1;
                    end
                    if (bus.Halt) begin
                        state_q <= HALTED;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= FETCH;
                        pc_q    <= pc_next_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.InstAddr    = pc_q;
    assign bus.Instruction = inst_q;
    assign bus.InstValid   = valid_q;
    assign bus.Done        = done_q;
    assign bus.InstCount   = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed programs against an instruction-level model of the
// fetch unit, compared every cycle, plus hand-computed trace/value checks.
module tb_fetch_unit;

    localparam int AW    = processor_pkg::PC_W;
    localparam int KW    = processor_pkg::KEY_W;
    localparam int DEPTH = 1 << AW;
    localparam int LUT_N = 1 << KW;

    // Bench instruction encoding: {op[3:0], key[4:0]}.
    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_HALT    = 4'h7;
    localparam logic [3:0] OP_BT      = 4'h8;
    localparam logic [3:0] OP_BF      = 4'h9;
    localparam logic [3:0] OP_HALT_BT = 4'hA;

    function automatic logic [AW-1:0] lut_entry(input int k);
        case (k)
`ifdef BRANCH_REL_EN
            2:       return 10'h3FD;  // -3
`else
            2:       return 10'd40;
`endif
            3:       return 10'd10;
            4:       return 10'h3FF;  // absolute 1023, or -1 as an offset from 0
            default: return AW'((k * 17 + 1) % DEPTH);
        endcase
    endfunction

    function automatic logic [LUT_N*AW-1:0] pack_lut();
        logic [LUT_N*AW-1:0] v;
        v = '0;
        for (int k = 0; k < LUT_N; k++) v[k*AW +: AW] = lut_entry(k);
        return v;
    endfunction

    localparam logic [LUT_N*AW-1:0] LUT_INIT = pack_lut();

    function automatic logic [8:0] enc(input logic [3:0] op, input logic [4:0] k);
        return {op, k};
    endfunction

    function automatic bit op_halts(input logic [3:0] op);
        return op == OP_HALT || op == OP_HALT_BT;
    endfunction

    function automatic bit op_looks(input logic [3:0] op);
        return op == OP_BT || op == OP_BF || op == OP_HALT_BT;
    endfunction

    function automatic bit op_sense(input logic [3:0] op);
        return op == OP_BT || op == OP_HALT_BT;
    endfunction

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       acc;
    logic [8:0] rom [DEPTH];

    always #5 clk = ~clk;

    fetch_unit_if #(.PC_W(AW)) bus ();

    assign bus.Start       = start;
    assign bus.AccNonZero  = acc;
    assign bus.RomData     = rom[bus.InstAddr];
    assign bus.Halt        = op_halts(bus.Instruction[8:5]);
    assign bus.LookUp      = op_looks(bus.Instruction[8:5]);
    assign bus.BranchSense = op_sense(bus.Instruction[8:5]);

    fetch_unit #(
        .PC_W     (AW),
        .KEY_W    (KW),
        .LUT_FILE (""),
        .LUT_INIT (LUT_INIT)
    ) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: mode 0 idle, 1 reading ROM, 2 issuing, 3 halted.
    int         m_mode  = 0;
    int         m_pc    = 0;
    int         m_count = 0;
    logic [8:0] m_inst  = '0;

    function automatic int branch_dest(input int pc, input int k);
`ifdef BRANCH_REL_EN
        return (pc + int'(lut_entry(k))) % DEPTH;
`else
        return int'(lut_entry(k));
`endif
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0; m_pc = 0; m_count = 0; m_inst = '0;
        end else begin
            case (m_mode)
                0, 3: if (start) begin m_mode = 1; m_pc = 0; m_count = 0; end
                1: begin m_inst = rom[m_pc]; m_mode = 2; end
                2: begin
                    if (m_count < 65535) m_count++;
                    if (op_halts(m_inst[8:5])) m_mode = 3;
                    else begin
                        if (op_looks(m_inst[8:5]) && (acc == op_sense(m_inst[8:5])))
                            m_pc = branch_dest(m_pc, int'(m_inst[4:0]));
                        else
                            m_pc = (m_pc + 1) % DEPTH;
                        m_mode = 1;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    end

    bit cmp_en = 1'b0;
    int trace[$];

    // Per-cycle compare against the model; also records every issued PC.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_addr",  32'(bus.InstAddr),    32'(m_pc));
            check("model_valid", 32'(bus.InstValid),   32'(m_mode == 2));
            check("model_done",  32'(bus.Done),        32'(m_mode == 3));
            check("model_count", 32'(bus.InstCount),   32'(m_count));
            check("model_inst",  32'(bus.Instruction), 32'(m_inst));
        end
        if (bus.InstValid === 1'b1) trace.push_back(int'(bus.InstAddr));
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < DEPTH; i++) rom[i] = enc(OP_NOP, 5'(i));
    endtask

    task automatic pulse_start(input int hold);
        trace.delete();
        start = 1'b1;
        tick(hold);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        while (bus.Done !== 1'b1 && n < bound) begin tick(); n++; end
        check({name, "_done"}, 32'(bus.Done), 32'd1);
    endtask

    task automatic check_trace(input string name, input int exp[$]);
        check({name, "_len"}, 32'(trace.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < trace.size(); i++)
            check($sformatf("%s_%0d", name, i), 32'(trace[i]), 32'(exp[i]));
    endtask

    task automatic check_idle_zero(input string name);
        check({name, "_addr"},  32'(bus.InstAddr),    32'd0);
        check({name, "_inst"},  32'(bus.Instruction), 32'd0);
        check({name, "_valid"}, 32'(bus.InstValid),   32'd0);
        check({name, "_done"},  32'(bus.Done),        32'd0);
        check({name, "_count"}, 32'(bus.InstCount),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        start = 1'b0; acc = 1'b0; rst_n = 1'b0;
        clear_rom();

        // Reset low for two edges, then release and stay idle.
        @(negedge clk);
        cmp_en = 1'b1;
        tick();
        check_idle_zero("reset");
        rst_n = 1'b1;
        tick();
        check_idle_zero("idle");

        // Three plain instructions then a halt.
        rom[3] = enc(OP_HALT, 5'd0);
        pulse_start(1);
        check("start_addr",  32'(bus.InstAddr),  32'd0);
        check("start_valid", 32'(bus.InstValid), 32'd0);
        tick();
        check("first_valid", 32'(bus.InstValid), 32'd1);
        wait_done("progA", 40);
        check_trace("progA", '{0, 1, 2, 3});
        check("progA_count", 32'(bus.InstCount), 32'd4);
        tick(3);
        check("progA_hold_addr", 32'(bus.InstAddr), 32'd3);
        check("progA_hold_done", 32'(bus.Done),     32'd1);

`ifdef BRANCH_REL_EN
        // bt +10 from PC 0, then bt -3 from PC 10 lands on the halt at 7.
        clear_rom();
        rom[0] = enc(OP_BT, 5'd3); rom[10] = enc(OP_BT, 5'd2);
        rom[7] = enc(OP_HALT, 5'd0); rom[11] = enc(OP_HALT, 5'd0);
        acc = 1'b1;
        pulse_start(1);
        wait_done("rel_bt", 40);
        check_trace("rel_bt", '{0, 10, 7});
        check("rel_bt_addr", 32'(bus.InstAddr), 32'd7);
        // Same path with bf and a zero accumulator.
        rom[0] = enc(OP_BF, 5'd3); rom[10] = enc(OP_BF, 5'd2);
        acc = 1'b0;
        pulse_start(1);
        wait_done("rel_bf", 40);
        check_trace("rel_bf", '{0, 10, 7});
`else
        // bt at PC 5 with key 2 (target 40): taken, then not taken.
        clear_rom();
        rom[5] = enc(OP_BT, 5'd2); rom[6] = enc(OP_HALT, 5'd0); rom[40] = enc(OP_HALT, 5'd0);
        acc = 1'b1;
        pulse_start(1);
        wait_done("bt_taken", 40);
        check_trace("bt_taken", '{0, 1, 2, 3, 4, 5, 40});
        check("bt_taken_addr",  32'(bus.InstAddr),  32'd40);
        check("bt_taken_count", 32'(bus.InstCount), 32'd7);
        acc = 1'b0;
        pulse_start(1);
        wait_done("bt_not", 40);
        check_trace("bt_not", '{0, 1, 2, 3, 4, 5, 6});
        check("bt_not_addr", 32'(bus.InstAddr), 32'd6);
        // bf with a zero accumulator is taken.
        rom[5] = enc(OP_BF, 5'd2);
        pulse_start(1);
        wait_done("bf_taken", 40);
        check_trace("bf_taken", '{0, 1, 2, 3, 4, 5, 40});
`endif

        // Halt and branch together: halt wins; Start held through FETCH/ISSUE is ignored.
        clear_rom();
        rom[0] = enc(OP_HALT_BT, 5'd2);
        acc = 1'b1;
        pulse_start(3);
        wait_done("halt_br", 10);
        check_trace("halt_br", '{0});
        check("halt_br_addr",  32'(bus.InstAddr),  32'd0);
        check("halt_br_count", 32'(bus.InstCount), 32'd1);

        // Branch to 1023, plain instruction wraps to 0, then reset mid-ISSUE.
        clear_rom();
        rom[0] = enc(OP_BT, 5'd4);
        acc = 1'b1;
        pulse_start(1);
        n = 0;
        while (!(bus.InstValid === 1'b1 && bus.InstAddr === AW'(1023)) && n < 20) begin
            tick(); n++;
        end
        check("wrap_reach", 32'(bus.InstAddr), 32'd1023);
        tick();
        check("wrap_addr",  32'(bus.InstAddr),  32'd0);
        check("wrap_count", 32'(bus.InstCount), 32'd2);
        tick();
        check("wrap_issue_valid", 32'(bus.InstValid), 32'd1);
        rst_n = 1'b0;
        tick();
        check_idle_zero("mid_reset");
        rst_n = 1'b1;
        tick(2);
        check_idle_zero("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 10, meaning program counter width.
REQ-002 SHALL have parameter KEY_W, default 5, meaning branch lookup-table key width.
REQ-003 SHALL have one clock and a synchronous, active-low reset: Clk and Reset.
REQ-004 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Reset  input  1  synchronous active-low reset; sampled only on a Clk rising edge.
REQ-006 Start  input  1  begin execution from PC 0.
REQ-007 Halt  input  1  decoder halt indication for the issued instruction.
REQ-008 LookUp  input  1  decoder branch indication for the issued instruction.
REQ-009 BranchSense  input  1  1 = bt (branch if AccNonZero), 0 = bf (branch if !AccNonZero).
REQ-010 AccNonZero  input  1  accumulator != 0, supplied by the datapath.
REQ-011 InstAddr  output  PC_W  instruction ROM address; equals PC.
REQ-012 RomData  input  9  ROM read data; valid one cycle after InstAddr.
REQ-013 Instruction  output  9  registered instruction ({TypeBit, OP, reg}) presented to the decoder.
REQ-014 InstValid  output  1  Instruction is valid this cycle.
REQ-015 Done  output  1  program halted.
REQ-016 InstCount  output  16  count of issued instructions, saturating.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, ISSUE and HALTED.
REQ-018 IDLE: Start=1 -> FETCH with PC=0 and InstCount=0; otherwise hold.
REQ-019 FETCH: latch RomData into Instruction; -> ISSUE next cycle (one instruction per 2 cycles).
REQ-020 ISSUE: InstValid=1 for exactly this cycle; InstCount increments and saturates at 16'hFFFF.
REQ-021 ISSUE with Halt=1 -> HALTED; PC is unchanged; Halt has priority over LookUp.
REQ-022 ISSUE with LookUp=1 and (AccNonZero==BranchSense) -> FETCH with PC = branch target.
REQ-023 ISSUE otherwise -> FETCH with PC = PC+1, wrapping from 2^PC_W-1 to 0.
REQ-024 Branch key SHALL be Instruction[KEY_W-1:0]; the target comes from a 2^KEY_W-entry table of PC_W-bit entries, initialised from file branch_lut.hex.
REQ-025 HALTED: Done=1; Start=1 -> FETCH with PC=0 and InstCount=0; otherwise hold.
REQ-026 Start SHALL be ignored in FETCH and ISSUE.
REQ-027 InstValid SHALL be 0 in IDLE, FETCH and HALTED; Done SHALL be 0 outside HALTED.

Reset
REQ-028 Reset=0 at any edge, including mid-instruction, SHALL force IDLE, PC=0, Instruction=0, InstValid=0, Done=0 and InstCount=0 on that edge.
REQ-029 Reset SHALL override Start and all other inputs.

Configuration
REQ-030 Macro BRANCH_REL_EN defined: the table entry SHALL be a signed PC_W-bit offset and target = PC + entry, modulo 2^PC_W.
REQ-031 Macro BRANCH_REL_EN undefined: the table entry SHALL be the absolute target PC.

Structure
REQ-032 Package processor_pkg SHALL hold the fetch_state_t enum and the constants PC_W, INST_W=9 and KEY_W.
REQ-033 The table SHALL be a sub-module branch_lut: combinational read, KEY_W-bit key in, PC_W-bit value out.

Verification
REQ-034 Reset low for 2 cycles, then high -> all outputs 0 and state IDLE; Start pulse -> InstAddr=0, and InstValid first high 2 cycles later.
REQ-035 ROM holding 3 non-branch instructions followed by a halt -> InstAddr sequence 0,1,2,3; then Done=1, InstCount=4, and InstAddr held at 3.
REQ-036 bt at PC 5 with key 2, lut[2]=40, AccNonZero=1 -> next InstAddr=40; repeat with AccNonZero=0 -> next InstAddr=6.
REQ-037 Halt=1 and LookUp=1 in the same ISSUE cycle -> HALTED entered and no redirect; with BRANCH_REL_EN, lut[2]=-3 at PC 10 -> InstAddr=7.
REQ-038 Non-branch instruction at PC 1023 -> InstAddr wraps to 0; Reset asserted during ISSUE -> IDLE next cycle with InstCount=0.
